// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like slave port between the instruction and
// data masters. Grant and all handshakes are combinational pass-through. An
// in-order owner FIFO routes every data_ok/rdata back to the master that
// issued the transaction.
// Optional build macro SRAM_ARB_RR_EN: round-robin priority instead of the
// fixed data-over-inst priority.
module sram_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction master
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data master
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // shared slave
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    // owner encoding: 0 = inst, 1 = data
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       lock_valid_q, lock_valid_d;
    logic                       lock_owner_q, lock_owner_d;
`ifdef SRAM_ARB_RR_EN
    logic                       last_owner_q, last_owner_d;
`endif

    logic gnt;      // 1 = data master granted
    logic full;
    logic push;
    logic pop;
    logic head_owner;

    assign full       = (count_q == FULL_CNT);
    assign head_owner = owner_q[rptr_q];

    // Grant: a live lock wins; otherwise contention goes by priority policy.
    always_comb begin
        gnt = data_req;
        if (lock_valid_q && (lock_owner_q ? data_req : inst_req)) begin
            gnt = lock_owner_q;
        end else if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
            gnt = ~last_owner_q;
`else
            gnt = 1'b1;
`endif
        end
    end

    // Request mux and handshake routing; everything is forced quiet in reset.
    always_comb begin
        mem_req      = (gnt ? data_req : inst_req) & ~full & ~reset;
        mem_wr       = gnt ? data_wr    : inst_wr;
        mem_size     = gnt ? data_size  : inst_size;
        mem_wstrb    = gnt ? data_wstrb : inst_wstrb;
        mem_addr     = gnt ? data_addr  : inst_addr;
        mem_wdata    = gnt ? data_wdata : inst_wdata;
        push         = mem_req & mem_addr_ok;
        // a response with nothing outstanding is a slave error and is dropped
        pop          = mem_data_ok & (count_q != '0) & ~reset;
        inst_addr_ok = push & ~gnt;
        data_addr_ok = push &  gnt;
        inst_data_ok = pop & ~head_owner;
        data_data_ok = pop &  head_owner;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // Next state of the owner FIFO, the lock and the round-robin pointer.
    always_comb begin
        owner_d      = owner_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        if (push) begin
            owner_d[wptr_q] = gnt;
            wptr_d          = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // hold the grant while the slave has seen mem_req but not accepted it
        lock_valid_d = mem_req & ~mem_addr_ok;
        lock_owner_d = lock_valid_d ? gnt : lock_owner_q;
`ifdef SRAM_ARB_RR_EN
        last_owner_d = push ? gnt : last_owner_q;
`endif
    end

    // State registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            owner_q      <= owner_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
`ifdef SRAM_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end
endmodule
